// File: rtl/key_tracker_pkg.sv
// key_tracker_pkg
// Shared constants and helpers for the PS/2 key tracker:
//   - scan-code prefix bytes (break F0, extended E0)
//   - octave key make codes (F1 = 05, F2 = 06)
//   - parser state encoding
//   - membership test for the 37 note keys that noteLUT understands
package key_tracker_pkg;

  localparam int KEY_W = 8;

  localparam logic [KEY_W-1:0] KC_BREAK  = 8'hF0;
  localparam logic [KEY_W-1:0] KC_EXT    = 8'hE0;
  localparam logic [KEY_W-1:0] KC_OCT_DN = 8'h05;
  localparam logic [KEY_W-1:0] KC_OCT_UP = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parse_state_e;

  // True for exactly the set-2 make codes that noteLUT maps to a note.
  function automatic logic is_note_key(input logic [KEY_W-1:0] code);
    case (code)
      8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C,
      8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45,
      8'h4D, 8'h54, 8'h55, 8'h5B, 8'h1A, 8'h1B, 8'h22, 8'h23,
      8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
      8'h41, 8'h4B, 8'h49, 8'h4C, 8'h4A: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_stack.sv
// key_stack
// Ordered set of held key codes. Slot 0 is the oldest entry, slot count-1
// the newest. Pushing a code already present does nothing; pushing into a
// full stack drops the oldest entry. Removing a code closes the gap so the
// remaining entries keep their relative order.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset (empties the stack)
//   push_i   in   insert code_i as newest entry (if not already present)
//   remove_i in   delete the entry equal to code_i (if present)
//   code_i   in   key code for push/remove
//   top_o    out  newest entry as it will be after this clock edge
//   empty_o  out  stack will be empty after this clock edge
//
// top_o/empty_o are look-ahead values (derived from next state) so the
// parent can register its outputs in the same edge as the stack update.
module key_stack
  import key_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             remove_i,
  input  logic [KEY_W-1:0] code_i,
  output logic [KEY_W-1:0] top_o,
  output logic             empty_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [KEY_W-1:0] entries_q [DEPTH];
  logic [KEY_W-1:0] entries_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [CW-1:0]    rm_idx;

  // Only slots below the fill level can match.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = (CW'(gi) < count_q) && (entries_q[gi] == code_i);
    end
  endgenerate

  assign hit = |match;

  // Codes are unique in the stack, so at most one match bit is set.
  always_comb begin
    rm_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) rm_idx = CW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_d[i] = entries_q[i];
    count_d = count_q;
    if (push_i && !hit) begin
      if (count_q == CW'(DEPTH)) begin
        // Full: shift everything one slot older, dropping slot 0.
        for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = entries_q[i+1];
        entries_d[DEPTH-1] = code_i;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_q) entries_d[i] = code_i;
        end
        count_d = count_q + 1'b1;
      end
    end else if (remove_i && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CW'(i) >= rm_idx) entries_d[i] = entries_q[i+1];
      end
      entries_d[DEPTH-1] = '0;
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) + 1'b1 == count_d) top_o = entries_d[i];
    end
  end

  assign empty_o = (count_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: rtl/key_tracker.sv
// key_tracker
// Turns a stream of PS/2 set-2 scan-code bytes into the current note key
// (last-note priority among held keys) plus an octave selector for noteLUT.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   rx_data[7:0]   in   scan-code byte from PS/2 receiver
//   rx_valid       in   one-cycle strobe qualifying rx_data
//   key_code[7:0]  out  make code of newest held note key (holds when none)
//   enable         out  at least one note key is held
//   GLOBAL_octave  out  current octave, 0..OCT_MAX
//   key_event      out  one-cycle pulse when {enable,key_code} changes
module key_tracker
  import key_tracker_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int OCT_RESET = 3,
  parameter int OCT_MAX   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] key_code,
  output logic       enable,
  output logic [2:0] GLOBAL_octave,
  output logic       key_event
);

  parse_state_e state_q, state_d;
  logic         make_byte;   // final byte of a make sequence
  logic         brk_byte;    // final byte of a break sequence
  logic         is_note;

  logic [7:0]   stk_top;
  logic         stk_empty;

  logic [2:0]   oct_q, oct_d;
  logic         up_held_q, up_held_d;
  logic         dn_held_q, dn_held_d;

  logic [7:0]   key_code_q, key_code_d;
  logic         enable_q, enable_d;
  logic         key_event_q, key_event_d;

  // Parser: extended sequences are recognised only so they can be skipped.
  always_comb begin
    state_d   = state_q;
    make_byte = 1'b0;
    brk_byte  = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == KC_BREAK)    state_d = ST_BRK;
          else if (rx_data == KC_EXT) state_d = ST_EXT;
          else                        make_byte = 1'b1;
        end
        ST_BRK: begin
          brk_byte = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT:     state_d = (rx_data == KC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign is_note = is_note_key(rx_data);

  key_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push_i   (make_byte && is_note),
    .remove_i (brk_byte && is_note),
    .code_i   (rx_data),
    .top_o    (stk_top),
    .empty_o  (stk_empty)
  );

  // Octave keys step only on a fresh press; typematic repeats see the
  // held flag still set and are ignored until the key is released.
  always_comb begin
    oct_d     = oct_q;
    up_held_d = up_held_q;
    dn_held_d = dn_held_q;
    if (make_byte && rx_data == KC_OCT_UP) begin
      up_held_d = 1'b1;
      if (!up_held_q && oct_q != 3'(OCT_MAX)) oct_d = oct_q + 3'd1;
    end
    if (make_byte && rx_data == KC_OCT_DN) begin
      dn_held_d = 1'b1;
      if (!dn_held_q && oct_q != 3'd0) oct_d = oct_q - 3'd1;
    end
    if (brk_byte && rx_data == KC_OCT_UP) up_held_d = 1'b0;
    if (brk_byte && rx_data == KC_OCT_DN) dn_held_d = 1'b0;
  end

  // Outputs are computed from the stack's look-ahead so they land in the
  // cycle right after the final byte.
  always_comb begin
    enable_d    = !stk_empty;
    key_code_d  = stk_empty ? key_code_q : stk_top;
    key_event_d = ({enable_d, key_code_d} != {enable_q, key_code_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      oct_q       <= 3'(OCT_RESET);
      up_held_q   <= 1'b0;
      dn_held_q   <= 1'b0;
      key_code_q  <= 8'h00;
      enable_q    <= 1'b0;
      key_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      oct_q       <= oct_d;
      up_held_q   <= up_held_d;
      dn_held_q   <= dn_held_d;
      key_code_q  <= key_code_d;
      enable_q    <= enable_d;
      key_event_q <= key_event_d;
    end
  end

  assign key_code      = key_code_q;
  assign enable        = enable_q;
  assign GLOBAL_octave = oct_q;
  assign key_event     = key_event_q;

endmodule

// File: tb/tb_key_tracker.sv
// tb_key_tracker
// Directed byte sequences; every byte pushes the expected outputs for the
// following cycle into a queue, which is popped and compared one cycle later.
module tb_key_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] key_code;
  logic       enable;
  logic [2:0] GLOBAL_octave;
  logic       key_event;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .key_code      (key_code),
    .enable        (enable),
    .GLOBAL_octave (GLOBAL_octave),
    .key_event     (key_event)
  );

  typedef struct {
    logic       en;
    logic [7:0] kc;
    logic       ev;
    logic [2:0] oct;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_stack[$];   // newest at back
  int         m_state;      // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
  int         m_oct;
  logic       m_uh, m_dh;
  logic       m_en;
  logic [7:0] m_kc;

  logic [7:0] note_list [37] = '{
    8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C,
    8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43, 8'h46, 8'h44, 8'h45,
    8'h4D, 8'h54, 8'h55, 8'h5B, 8'h1A, 8'h1B, 8'h22, 8'h23,
    8'h21, 8'h2A, 8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A,
    8'h41, 8'h4B, 8'h49, 8'h4C, 8'h4A};

  function automatic logic tb_is_note(input logic [7:0] b);
    for (int i = 0; i < 37; i++) if (note_list[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_stack.delete();
    m_state = 0;
    m_oct   = 3;
    m_uh    = 1'b0;
    m_dh    = 1'b0;
    m_en    = 1'b0;
    m_kc    = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic       found;
    logic       new_en;
    logic [7:0] new_kc;
    exp_t       e;
    case (m_state)
      0: begin
        if (b == 8'hF0)      m_state = 1;
        else if (b == 8'hE0) m_state = 2;
        else begin
          if (tb_is_note(b)) begin
            found = 1'b0;
            foreach (m_stack[i]) if (m_stack[i] == b) found = 1'b1;
            if (!found) begin
              if (m_stack.size() == 4) void'(m_stack.pop_front());
              m_stack.push_back(b);
            end
          end
          if (b == 8'h06) begin
            if (!m_uh && m_oct < 5) m_oct++;
            m_uh = 1'b1;
          end
          if (b == 8'h05) begin
            if (!m_dh && m_oct > 0) m_oct--;
            m_dh = 1'b1;
          end
        end
      end
      1: begin
        m_state = 0;
        if (tb_is_note(b)) begin
          for (int i = 0; i < m_stack.size(); i++) begin
            if (m_stack[i] == b) begin
              m_stack.delete(i);
              break;
            end
          end
        end
        if (b == 8'h06) m_uh = 1'b0;
        if (b == 8'h05) m_dh = 1'b0;
      end
      2: m_state = (b == 8'hF0) ? 3 : 0;
      default: m_state = 0;
    endcase
    new_en = (m_stack.size() > 0);
    new_kc = new_en ? m_stack[m_stack.size()-1] : m_kc;
    e.ev   = (new_en != m_en) || (new_kc != m_kc);
    e.en   = new_en;
    e.kc   = new_kc;
    e.oct  = 3'(m_oct);
    m_en   = new_en;
    m_kc   = new_kc;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one byte, compare the popped expectation in the next cycle, then
  // spend an idle cycle and confirm key_event has dropped.
  task automatic send(input logic [7:0] b);
    exp_t e;
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    e = exp_q.pop_front();
    chk($sformatf("en_%02h", b),  32'(enable),        32'(e.en));
    chk($sformatf("kc_%02h", b),  32'(key_code),      32'(e.kc));
    chk($sformatf("ev_%02h", b),  32'(key_event),     32'(e.ev));
    chk($sformatf("oct_%02h", b), 32'(GLOBAL_octave), 32'(e.oct));
    @(posedge clk);
    #1;
    chk("ev_idle", 32'(key_event), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_en"},  32'(enable),        32'd0);
    chk({tag, "_kc"},  32'(key_code),      32'h00);
    chk({tag, "_ev"},  32'(key_event),     32'd0);
    chk({tag, "_oct"}, 32'(GLOBAL_octave), 32'd3);
  endtask

  initial begin
    int ev_count;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("rst");

    // Single key press and release
    send(8'h15); send(8'hF0); send(8'h15);

    // Last-note priority with releases out of order
    send(8'h15); send(8'h1D); send(8'h24);
    send(8'hF0); send(8'h1D);
    chk("prio_24", 32'(key_code), 32'h24);
    send(8'hF0); send(8'h24);
    chk("prio_15", 32'(key_code), 32'h15);
    send(8'hF0); send(8'h15);
    chk("prio_off", 32'(enable), 32'd0);

    // Overflow drops the oldest key
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    send(8'hF0); send(8'h2C);
    chk("ovf_2d", 32'(key_code), 32'h2D);
    send(8'hF0); send(8'h15);   // already dropped: ignored
    send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h2D);
    send(8'hF0); send(8'h24);
    chk("ovf_off", 32'(enable), 32'd0);

    // Typematic repeat, extended break, non-note key
    ev_count = 0;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h15; rx_valid = 1'b1; model_byte(8'h15);
      @(posedge clk); #1; rx_valid = 1'b0;
      if (key_event === 1'b1) ev_count++;
      void'(exp_q.pop_front());
    end
    chk("typematic_events", 32'(ev_count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h15);
    chk("ext_brk_kc", 32'(key_code), 32'h15);
    chk("ext_brk_en", 32'(enable),   32'd1);
    send(8'h1C);
    chk("nonnote_kc", 32'(key_code), 32'h15);
    send(8'hF0); send(8'h15);

    // Octave up with typematic and saturation
    repeat (4) send(8'h06);
    chk("oct_up_4", 32'(GLOBAL_octave), 32'd4);
    send(8'hF0); send(8'h06);
    send(8'h06);
    chk("oct_up_5", 32'(GLOBAL_octave), 32'd5);
    send(8'hF0); send(8'h06);
    send(8'h06);
    chk("oct_sat_hi", 32'(GLOBAL_octave), 32'd5);
    send(8'hF0); send(8'h06);

    // Octave down to 0 and saturate there
    repeat (6) begin
      send(8'h05); send(8'hF0); send(8'h05);
    end
    chk("oct_sat_lo", 32'(GLOBAL_octave), 32'd0);

    // Abandon a partial break sequence with reset; a byte coincident with
    // reset must also be ignored.
    send(8'hF0);
    reset    = 1'b1;
    rx_data  = 8'h1D;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    model_reset();
    check_reset_state("rst2");
    send(8'h15);
    chk("post_rst_kc", 32'(key_code), 32'h15);
    chk("post_rst_en", 32'(enable),   32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
